cle_sram_arbiter: RTL and testbench
===================================

Name: cle_sram_arbiter

Overview:
- Shares the single-port sram_1024x8_t13 (CEN tied low) between two requesters of the CLE flow.
- Master 0 is the ROM-to-bitmap unpack loader. Master 1 is the labeling scan engine that reads pixels and writes labels.
- Round-robin ownership with burst limit and lock. Registered SRAM-side address/data/write-enable. Read-return tagging back to the issuing master.

Parameters:
- AW, 10, SRAM address width
- DW, 8, SRAM data width
- MAX_BURST, 8, beats an owner may issue before yielding to a waiting, non-locked contender (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock, asynchronous, active-high
- m0_req  in  1  master 0 access request; hold with stable a/d/wen until accepted
- m0_lock  in  1  master 0 keeps ownership past MAX_BURST while high
- m0_wen  in  1  0 = write, 1 = read (SRAM polarity)
- m0_a  in  AW  master 0 address
- m0_d  in  DW  master 0 write data
- m0_gnt  out  1  master 0 owns the SRAM this cycle
- m0_rvalid  out  1  m0_rdata carries data for an earlier m0 read
- m0_rdata  out  DW  read data (sram_q pass-through)
- m1_req, m1_lock, m1_wen, m1_a, m1_d, m1_gnt, m1_rvalid, m1_rdata: same as master 0
- sram_q  in  DW  SRAM read data
- sram_a  out  AW  registered SRAM address
- sram_d  out  DW  registered SRAM write data
- sram_wen  out  1  registered SRAM write enable, active-low
- arb_idle  out  1  no owner and no read in flight

Behaviour:
- Reset values: sram_a=0, sram_d=0, sram_wen=1, m0_gnt=m1_gnt=0, rvalid=0, state=IDLE, rr_ptr=0, beat_cnt=0, arb_idle=1.
- States: IDLE, OWN0, OWN1. gntX is registered and high only in OWNX.
- Accept: an access is accepted at a rising edge where mX_req && mX_gnt. At that edge sram_a<=mX_a, sram_d<=mX_d, sram_wen<=mX_wen. At any edge without an accept, sram_wen<=1 and sram_a/sram_d hold.
- Read latency: accept at edge E0 → SRAM samples at E1 → mX_rvalid high for exactly the one cycle after E1, with mX_rdata = sram_q.
  - Back-to-back reads give back-to-back rvalid.
  - The read tag is a 2-stage pipe {valid, id}, so a read is returned to its issuer even after ownership moves.
  - The non-matching rdata output is don't-care; implemented as the same sram_q.
- IDLE:
  - Only one req: go to that OWN.
  - Both req: go to OWN[rr_ptr].
  - Neither req: stay in IDLE.
  - Grant appears the cycle after req is first seen (1-cycle grant latency).
- OWNX, evaluated each edge:
  - beat_cnt increments on each accept.
  - Yield condition: mX_req low, OR (beat_cnt reaches MAX_BURST including this accept, AND other req high, AND mX_lock low).
  - On yield with other req high: direct switch to OWN(other), no bubble, beat_cnt<=0, rr_ptr<=other.
  - On yield with other req low: go to IDLE, rr_ptr<=other.
  - Owner still requesting with no contender: ownership kept; beat_cnt saturates at MAX_BURST.
- Lock: lock never blocks release when the owner drops req. Lock sampled while not owner has no effect.
- Same-address write-then-read across masters is ordered by acceptance order; no forwarding is needed.
- arb_idle = (state==IDLE) && no read tag in flight.
- Reset mid-burst: all state returns to reset values immediately. In-flight rvalid is discarded and never asserts after reset.

Optional Feature:
- Macro: CLE_ARB_FIXED_PRIO_EN.
- Defined:
  - Master 1 (scan engine) has strict priority.
  - From IDLE with both req, go to OWN1.
  - In OWN0, yield at the first beat boundary where m1_req is high and m0_lock is low, regardless of MAX_BURST.
  - OWN1 never yields to master 0 until m1_req drops.
  - rr_ptr is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset during traffic: m0 streams 3 writes, reset asserted asynchronously mid-cycle → sram_wen=1, gnts 0, arb_idle=1 before the next edge; no rvalid afterwards.
- Single master write/read: m0 writes 0x01 to 0x3FF, then reads 0x3FF → m0_gnt 1 cycle after req; m0_rvalid one cycle, 2 edges after the read accept, with m0_rdata=0x01; m1_rvalid stays 0.
- Round-robin: both req continuously with lock=0, MAX_BURST=8 → grant alternates every 8 accepts, starting with m0 after reset; no idle cycle at switchover; 16 accepts in 16 cycles.
- Lock: m0_lock=1 with m0 streaming 20 writes and m1 requesting → m0 keeps grant for all 20 beats; m1_gnt rises the cycle after m0_req drops.
- Read return across switchover: m0 reads 0x010 (data 0xAA) on its last beat, m1 immediately reads 0x020 (0x55) → m0_rvalid with 0xAA, then m1_rvalid with 0x55 on the next cycle.
- CLE_ARB_FIXED_PRIO_EN: m0 bursting unlocked, m1_req rises → m0 yields after the current beat; m1 holds the grant through 30 beats despite m0_req high.

Source files
------------

// File: rtl/cle_sram_arbiter.sv
// rtl/cle_sram_arbiter.sv - two-master round-robin SRAM arbiter with burst limit, lock and read-return tagging (option: CLE_ARB_FIXED_PRIO_EN)
module cle_sram_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 8,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_wen,
    input  logic [AW-1:0] m0_a,
    input  logic [DW-1:0] m0_d,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_wen,
    input  logic [AW-1:0] m1_a,
    input  logic [DW-1:0] m1_d,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    input  logic [DW-1:0] sram_q,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_wen,
    output logic          arb_idle
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t        state;
    logic          rr_ptr;
    logic [3:0]    beat_cnt;
    logic          tag1_v, tag1_id, tag2_v, tag2_id;

    logic          own_id;
    logic          own_req;
    logic          own_lock;
    logic          oth_req;
    logic          accept;
    logic          sel_wen;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_d;
    logic [3:0]    cnt_next;
    logic          burst_done;
    logic          yield;
    logic          idle_pick1;

    always_comb begin
        own_id     = (state == OWN1);
        own_req    = own_id ? m1_req  : m0_req;
        own_lock   = own_id ? m1_lock : m0_lock;
        oth_req    = own_id ? m0_req  : m1_req;
        accept     = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);
        sel_wen    = own_id ? m1_wen : m0_wen;
        sel_a      = own_id ? m1_a   : m0_a;
        sel_d      = own_id ? m1_d   : m0_d;
        // Count saturates so a lone long burst never wraps back below the limit.
        cnt_next   = (accept && beat_cnt != MAX_B) ? beat_cnt + 4'd1 : beat_cnt;
        burst_done = (cnt_next >= MAX_B);
`ifdef CLE_ARB_FIXED_PRIO_EN
        idle_pick1 = 1'b1;
        if (own_id)
            yield = !m1_req;
        else
            yield = !m0_req || (m1_req && !m0_lock);
`else
        idle_pick1 = rr_ptr;
        yield      = !own_req || (burst_done && oth_req && !own_lock);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= 4'd0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            sram_a   <= '0;
            sram_d   <= '0;
            sram_wen <= 1'b1;
            tag1_v   <= 1'b0;
            tag1_id  <= 1'b0;
            tag2_v   <= 1'b0;
            tag2_id  <= 1'b0;
        end else begin
            sram_wen <= 1'b1;
            if (accept) begin
                sram_a   <= sel_a;
                sram_d   <= sel_d;
                sram_wen <= sel_wen;
            end
            // Tag follows the access through the SRAM so data returns to its issuer after a switch.
            tag1_v  <= accept && sel_wen;
            tag1_id <= own_id;
            tag2_v  <= tag1_v;
            tag2_id <= tag1_id;

            case (state)
                IDLE: begin
                    beat_cnt <= 4'd0;
                    if ((m0_req && m1_req && idle_pick1) || (m1_req && !m0_req)) begin
                        state  <= OWN1;
                        m1_gnt <= 1'b1;
                    end else if (m0_req) begin
                        state  <= OWN0;
                        m0_gnt <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (yield) begin
                        beat_cnt <= 4'd0;
                        rr_ptr   <= ~own_id;
                        if (oth_req) begin
                            state  <= own_id ? OWN0 : OWN1;
                            m0_gnt <= own_id;
                            m1_gnt <= ~own_id;
                        end else begin
                            state  <= IDLE;
                            m0_gnt <= 1'b0;
                            m1_gnt <= 1'b0;
                        end
                    end else begin
                        beat_cnt <= cnt_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    m0_gnt   <= 1'b0;
                    m1_gnt   <= 1'b0;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign m0_rvalid = tag2_v && !tag2_id;
    assign m1_rvalid = tag2_v && tag2_id;
    assign m0_rdata  = sram_q;
    assign m1_rdata  = sram_q;
    assign arb_idle  = (state == IDLE) && !tag1_v && !tag2_v;

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// tb/tb_cle_sram_arbiter.sv - directed vector bench for cle_sram_arbiter
module tb_cle_sram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m0_req, m0_lock, m0_wen, m1_req, m1_lock, m1_wen;
    logic [9:0] m0_a, m1_a, sram_a;
    logic [7:0] m0_d, m1_d, m0_rdata, m1_rdata, sram_q, sram_d;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_wen, arb_idle;
    logic [7:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cle_sram_arbiter #(.AW(10), .DW(8), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen), .m0_a(m0_a), .m0_d(m0_d),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_a(m1_a), .m1_d(m1_d),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen),
        .arb_idle(arb_idle)
    );

    // SRAM model: one-cycle synchronous read, write on active-low wen.
    always @(posedge clk) begin
        if (!sram_wen) mem[sram_a] <= sram_d;
        else           sram_q <= mem[sram_a];
    end

    typedef struct {
        logic       m0_req; logic m0_wen; logic [9:0] m0_a; logic [7:0] m0_d;
        logic       m1_req; logic m1_wen; logic [9:0] m1_a; logic [7:0] m1_d;
        logic       e_gnt0; logic e_gnt1; logic e_rv0; logic e_rv1; logic [7:0] e_rdata;
        logic       e_wen;  logic [9:0] e_a; logic e_idle;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic lock, input logic wen, input logic [9:0] a, input logic [7:0] d);
        m0_req = req; m0_lock = lock; m0_wen = wen; m0_a = a; m0_d = d;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic wen, input logic [9:0] a, input logic [7:0] d);
        m1_req = req; m1_lock = lock; m1_wen = wen; m1_a = a; m1_d = d;
    endtask

    task automatic do_reset();
        set_m0(0, 0, 1, 10'h0, 8'h0);
        set_m1(0, 0, 1, 10'h0, 8'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        vecs[0]  = '{1,0,10'h3FF,8'h01, 0,1,10'h000,8'h00, 0,0,0,0,8'h00, 1,10'h000,1};
        vecs[1]  = '{1,0,10'h3FF,8'h01, 0,1,10'h000,8'h00, 1,0,0,0,8'h00, 1,10'h000,0};
        vecs[2]  = '{1,1,10'h3FF,8'h00, 0,1,10'h000,8'h00, 1,0,0,0,8'h00, 0,10'h3FF,0};
        vecs[3]  = '{0,1,10'h3FF,8'h00, 0,1,10'h000,8'h00, 1,0,0,0,8'h00, 1,10'h3FF,0};
        vecs[4]  = '{0,1,10'h000,8'h00, 0,1,10'h000,8'h00, 0,0,1,0,8'h01, 1,10'h3FF,0};
        vecs[5]  = '{1,0,10'h005,8'h77, 1,1,10'h3FF,8'h00, 0,0,0,0,8'h00, 1,10'h3FF,1};
        vecs[6]  = '{1,0,10'h005,8'h77, 1,1,10'h3FF,8'h00, 0,1,0,0,8'h00, 1,10'h3FF,0};
        vecs[7]  = '{1,0,10'h005,8'h77, 0,1,10'h000,8'h00, 0,1,0,0,8'h00, 1,10'h3FF,0};
        vecs[8]  = '{1,0,10'h005,8'h77, 0,1,10'h000,8'h00, 1,0,0,1,8'h01, 1,10'h3FF,0};
        vecs[9]  = '{0,1,10'h000,8'h00, 0,1,10'h000,8'h00, 1,0,0,0,8'h00, 0,10'h005,0};
        vecs[10] = '{0,1,10'h000,8'h00, 0,1,10'h000,8'h00, 0,0,0,0,8'h00, 1,10'h005,1};

        // Single-master write/read, then idle arbitration with rr_ptr moved to m1.
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("v%0d_gnt0", i), m0_gnt, vecs[i].e_gnt0);
            chk($sformatf("v%0d_gnt1", i), m1_gnt, vecs[i].e_gnt1);
            chk($sformatf("v%0d_rv0", i), m0_rvalid, vecs[i].e_rv0);
            chk($sformatf("v%0d_rv1", i), m1_rvalid, vecs[i].e_rv1);
            if (vecs[i].e_rv0) chk($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rv1) chk($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_wen", i), sram_wen, vecs[i].e_wen);
            chk($sformatf("v%0d_a", i), sram_a, vecs[i].e_a);
            chk($sformatf("v%0d_idle", i), arb_idle, vecs[i].e_idle);
            set_m0(vecs[i].m0_req, 0, vecs[i].m0_wen, vecs[i].m0_a, vecs[i].m0_d);
            set_m1(vecs[i].m1_req, 0, vecs[i].m1_wen, vecs[i].m1_a, vecs[i].m1_d);
            @(negedge clk);
        end

        // Lock: m0 keeps ownership for 20 beats while m1 waits.
        do_reset();
        acc = 0;
        set_m0(1, 1, 0, 10'h040, 8'h5A);
        set_m1(1, 0, 0, 10'h041, 8'hA5);
        for (int k = 0; k <= 22; k++) begin
            if (k >= 1 && k <= 21) begin
                chk($sformatf("lock_k%0d_gnt0", k), m0_gnt, 1'b1);
                chk($sformatf("lock_k%0d_gnt1", k), m1_gnt, 1'b0);
            end
            if (k >= 2 && k <= 21 && !sram_wen) acc++;
            if (k == 21) m0_req = 1'b0;
            if (k == 22) begin
                chk("lock_gnt0_after_drop", m0_gnt, 1'b0);
                chk("lock_gnt1_after_drop", m1_gnt, 1'b1);
            end
            @(negedge clk);
        end
        chk("lock_accepts", acc, 20);

        // Reset mid-cycle with a read return in flight.
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            if (k == 3) set_m0(1, 0, 1, 10'h001, 8'h00);
            else        set_m0(1, 0, 0, 10'h001, 8'h11 + 8'(k));
            if (k == 5) begin
                chk("rst_pre_rv0", m0_rvalid, 1'b1);
                chk("rst_pre_wen", sram_wen, 1'b0);
            end else begin
                @(negedge clk);
            end
        end
        reset = 1'b1;
        #1;
        chk("rst_wen", sram_wen, 1'b1);
        chk("rst_gnt0", m0_gnt, 1'b0);
        chk("rst_gnt1", m1_gnt, 1'b0);
        chk("rst_idle", arb_idle, 1'b1);
        chk("rst_rv0", m0_rvalid, 1'b0);
        chk("rst_a", sram_a, 10'h000);
        set_m0(0, 0, 1, 10'h0, 8'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_post%0d_rv", k), {m0_rvalid, m1_rvalid}, 2'b00);
            chk($sformatf("rst_post%0d_idle", k), arb_idle, 1'b1);
            @(negedge clk);
        end

`ifndef CLE_ARB_FIXED_PRIO_EN
        // Round-robin: both streaming, 8-beat alternation starting with m0, no bubble.
        do_reset();
        acc = 0;
        set_m0(1, 0, 0, 10'h100, 8'h10);
        set_m1(1, 0, 0, 10'h200, 8'h20);
        for (int k = 0; k <= 18; k++) begin
            chk($sformatf("rr_k%0d_gnt0", k), m0_gnt, (k >= 1 && k <= 8) || k >= 17);
            chk($sformatf("rr_k%0d_gnt1", k), m1_gnt, k >= 9 && k <= 16);
            if (k >= 2 && k <= 17 && !sram_wen) acc++;
            @(negedge clk);
        end
        chk("rr_accepts", acc, 16);

        // Read return across a burst-limit switchover.
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k >= 1 && k <= 8) chk($sformatf("xr_k%0d_gnt0", k), m0_gnt, 1'b1);
            if (k == 9) begin
                chk("xr_gnt1", m1_gnt, 1'b1);
                chk("xr_gnt0", m0_gnt, 1'b0);
            end
            if (k == 10) begin
                chk("xr_rv0", {m0_rvalid, m1_rvalid}, 2'b10);
                chk("xr_rdata0", m0_rdata, 8'hAA);
            end
            if (k == 11) begin
                chk("xr_rv1", {m0_rvalid, m1_rvalid}, 2'b01);
                chk("xr_rdata1", m1_rdata, 8'h55);
            end
            if (k == 12) chk("xr_rv_done", {m0_rvalid, m1_rvalid}, 2'b00);
            if (k <= 1)      set_m0(1, 0, 0, 10'h010, 8'hAA);
            else if (k == 2) set_m0(1, 0, 0, 10'h020, 8'h55);
            else if (k <= 7) set_m0(1, 0, 0, 10'h100, 8'h00);
            else if (k == 8) set_m0(1, 0, 1, 10'h010, 8'h00);
            else             set_m0(0, 0, 1, 10'h000, 8'h00);
            set_m1(k <= 9, 0, 1, 10'h020, 8'h00);
            @(negedge clk);
        end
`else
        // Fixed priority: m0 yields on the first beat where m1 requests; m1 then holds.
        do_reset();
        set_m0(1, 0, 0, 10'h100, 8'h10);
        for (int k = 0; k <= 32; k++) begin
            if (k == 1) chk("fp_gnt0", m0_gnt, 1'b1);
            if (k == 2) set_m1(1, 0, 0, 10'h200, 8'h20);
            if (k >= 3) begin
                chk($sformatf("fp_k%0d_gnt1", k), m1_gnt, 1'b1);
                chk($sformatf("fp_k%0d_gnt0", k), m0_gnt, 1'b0);
            end
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
